// File: rtl/frog_collision.sv
// frog_collision: per-frame frog/car overlap check against a lane memory row.
// Each accepted frame_tick fetches the car row at the frog's row, tests the
// frog's column, and filters overlaps over consecutive frames before raising hit.
// Optional macro HIT_LATCH_EN: when defined, hit is sticky until reset;
// otherwise hit is a one-cycle pulse and the streak restarts after each hit.
module frog_collision #(
  parameter int unsigned ROW_W         = 16,
  parameter int unsigned READ_LAT      = 1,
  parameter int unsigned HIT_FRAMES    = 1,
  parameter logic [15:0] SAFE_ROW_MASK = 16'h8001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick_i,
  input  logic [3:0]       frog_row_i,
  input  logic [3:0]       frog_col_i,
  output logic [3:0]       car_row_addr_o,
  input  logic [ROW_W-1:0] car_pixels_i,
  output logic             busy_o,
  output logic             hit_o,
  output logic             overrun_o
);

  localparam int unsigned CNT_W      = 2;
  localparam int unsigned STREAK_W   = 4;
  localparam int unsigned STREAK_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COMPARE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          addr_q, addr_d;
  logic [3:0]          col_q, col_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [STREAK_W-1:0] streak_inc;
  logic                busy_q, busy_d;
  logic                hit_q, hit_d;
  logic                overrun_q, overrun_d;
  logic                overlap;

  // State and output registers; reset aborts any check in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      col_q     <= '0;
      streak_q  <= '0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      streak_q  <= streak_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      overrun_q <= overrun_d;
    end
  end

  // Saturating streak increment.
  always_comb begin
    streak_inc = streak_q;
    if (streak_q != STREAK_W'(STREAK_MAX)) begin
      streak_inc = streak_q + STREAK_W'(1);
    end
  end

  // Next-state and output logic; the address register doubles as the latched row.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    col_d     = col_q;
    streak_d  = streak_q;
`ifdef HIT_LATCH_EN
    hit_d     = hit_q;
`else
    hit_d     = 1'b0;
`endif
    overrun_d = frame_tick_i && (state_q != IDLE);
    overlap   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick_i) begin
          addr_d  = frog_row_i;
          col_d   = frog_col_i;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMPARE: begin
        overlap = car_pixels_i[col_q] & ~SAFE_ROW_MASK[addr_q];
        if (overlap) begin
          streak_d = streak_inc;
          if (streak_inc == STREAK_W'(HIT_FRAMES)) begin
            hit_d = 1'b1;
`ifndef HIT_LATCH_EN
            streak_d = '0;
`endif
          end
        end else begin
          streak_d = '0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign car_row_addr_o = addr_q;
  assign busy_o         = busy_q;
  assign hit_o          = hit_q;
  assign overrun_o      = overrun_q;

endmodule
